// File: rtl/alu_muldiv.sv
// Iterative RV64M/RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one accumulator pair, valid/ready on both sides.
module alu_muldiv #(
  parameter int unsigned XLEN      = 64,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [12:0]     md_op,
  input  logic [XLEN-1:0] md_src1,
  input  logic [XLEN-1:0] md_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result
);

  localparam int unsigned     CW       = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = x;
    return r;
  endfunction

  // Decode and operand preparation
  logic            op_legal, op_mul, op_word, op_high, op_rem;
  logic            sgn1, sgn2, sgn_div;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_op, fast_res;
  logic            neg1, neg2, div_zero, div_ovf, res_neg, fast, accept;

  always_comb begin
    op_legal = $onehot(md_op);
    op_mul   = |{md_op[12:9], md_op[4]};
    op_word  = |md_op[4:0];
    op_high  = |md_op[11:9];
    op_rem   = md_op[6] | md_op[5] | md_op[1] | md_op[0];
    sgn1     = |{md_op[12:10], md_op[8], md_op[6], md_op[4], md_op[3], md_op[1]};
    sgn2     = |{md_op[12:11], md_op[8], md_op[6], md_op[4], md_op[3], md_op[1]};
    sgn_div  = md_op[8] | md_op[6] | md_op[3] | md_op[1];

    ext1 = md_src1;
    ext2 = md_src2;
    if (op_word) begin
      ext1 = sgn1 ? sext32(md_src1[31:0]) : zext32(md_src1[31:0]);
      ext2 = sgn2 ? sext32(md_src2[31:0]) : zext32(md_src2[31:0]);
    end
    neg1 = sgn1 && ext1[XLEN-1];
    neg2 = sgn2 && ext2[XLEN-1];
    mag1 = neg1 ? -ext1 : ext1;
    mag2 = neg2 ? -ext2 : ext2;

    min_op   = op_word ? sext32(32'h8000_0000) : MIN_FULL;
    div_zero = !op_mul && (ext2 == '0);
    div_ovf  = sgn_div && (ext1 == min_op) && (ext2 == '1);

    // Zero divisor yields an all-ones quotient, so its sign must not follow s1^s2
    if (op_mul)      res_neg = neg1 ^ neg2;
    else if (op_rem) res_neg = neg1;
    else             res_neg = (neg1 ^ neg2) && !div_zero;

    fast     = (EARLY_OUT && (div_zero || div_ovf)) || ((XLEN == 32) && op_word);
    fast_res = '0;
    if ((XLEN != 32) || !op_word) begin
      if (div_zero) fast_res = op_rem ? (op_word ? sext32(md_src1[31:0]) : md_src1) : '1;
      else if (div_ovf) fast_res = op_rem ? '0 : min_op;
    end

    accept = in_valid && in_ready && op_legal && !flush;
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  // Iteration datapath: acc_hi/acc_lo hold product halves or remainder/quotient
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   opnd, acc_hi, acc_lo;
  logic              r_word, r_high, r_rem, r_neg;
  logic [XLEN:0]     mul_add, div_shift;
  logic [XLEN-1:0]   div_diff, hi_n, lo_n, fin_res;
  logic [2*XLEN-1:0] prod;
  logic              div_ge;

  always_comb begin
    mul_add   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (state == DIV) begin
      hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_n = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_add[XLEN:1];
      lo_n = {mul_add[0], acc_lo[XLEN-1:1]};
    end

    // Word multiplies stop after 32 shifts, leaving the product XLEN-32 bits high
    prod = {hi_n, lo_n};
    if (r_word) prod = prod >> (XLEN - 32);
    if (r_neg)  prod = -prod;

    if (state == DIV) begin
      fin_res = r_rem ? hi_n : lo_n;
      if (r_neg) fin_res = -fin_res;
    end else begin
      fin_res = r_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
    if (r_word) fin_res = sext32(fin_res[31:0]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = fast ? DONE : (op_mul ? MUL : DIV);
      MUL, DIV: if (cnt == CW'(1)) state_next = DONE;
      DONE:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      r_word    <= 1'b0;
      r_high    <= 1'b0;
      r_rem     <= 1'b0;
      r_neg     <= 1'b0;
      md_result <= '0;
    end else if (accept) begin
      cnt    <= op_word ? CW'(32) : CW'(XLEN);
      acc_hi <= '0;
      opnd   <= op_mul ? mag1 : mag2;
      acc_lo <= op_mul ? mag2 : (op_word ? (mag1 << (XLEN - 32)) : mag1);
      r_word <= op_word;
      r_high <= op_high;
      r_rem  <= op_rem;
      r_neg  <= res_neg;
      if (fast) md_result <= fast_res;
    end else if (((state == MUL) || (state == DIV)) && !flush) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) md_result <= fin_res;
    end
  end

endmodule
